// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped LED, free-running COUNTER, COMPARE and
// STATUS registers for a single-cycle core.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   memwrite   store strobe, one write per asserted cycle
//   addr       byte address (bits [1:0] ignored on reads)
//   writedata  store data
//   readdata   combinational load data for addr in the current cycle
//   leds       LED register contents (registered)
//   irq        STATUS.MATCH (registered)
module dmem_mmio #(
    parameter int unsigned RAM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  leds,
    output logic        irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    // Word addresses (addr[15:2]) of the MMIO registers
    localparam logic [13:0] LED_WADDR     = 14'h2000;
    localparam logic [13:0] COUNTER_WADDR = 14'h2001;
    localparam logic [13:0] COMPARE_WADDR = 14'h2002;
    localparam logic [13:0] STATUS_WADDR  = 14'h2003;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    led_q,     led_d;
    logic [31:0]   counter_q, counter_d;
    logic [31:0]   compare_q, compare_d;
    logic [1:0]    status_q,  status_d;   // [0] MATCH, [1] MISALIGN

    logic          dec_ok;
    logic          aligned;
    logic          ram_hit;
    logic          led_hit;
    logic          cnt_hit;
    logic          cmp_hit;
    logic          stat_hit;
    logic          wr_en;
    logic          ram_we;
    logic [AW-1:0] ram_idx;

    // Address decode shared by reads and writes
    always_comb begin
        dec_ok   = (addr[31:16] == 16'd0);
        aligned  = (addr[1:0] == 2'b00);
        ram_hit  = dec_ok && (32'(addr[15:2]) < RAM_WORDS);
        led_hit  = dec_ok && (addr[15:2] == LED_WADDR);
        cnt_hit  = dec_ok && (addr[15:2] == COUNTER_WADDR);
        cmp_hit  = dec_ok && (addr[15:2] == COMPARE_WADDR);
        stat_hit = dec_ok && (addr[15:2] == STATUS_WADDR);
        ram_idx  = addr[AW+1:2];
        wr_en    = memwrite && aligned;
        ram_we   = wr_en && ram_hit && !reset;
    end

    // Zero-latency read mux
    always_comb begin
        readdata = 32'd0;
        if (ram_hit) begin
            readdata = ram_q[ram_idx];
        end else if (led_hit) begin
            readdata = {24'd0, led_q};
        end else if (cnt_hit) begin
            readdata = counter_q;
        end else if (cmp_hit) begin
            readdata = compare_q;
        end else if (stat_hit) begin
            readdata = {30'd0, status_q};
        end
    end

    // Register next-state; STATUS sets are applied after W1C so set wins
    always_comb begin
        led_d     = led_q;
        counter_d = counter_q + 32'd1;
        compare_d = compare_q;
        status_d  = status_q;
        if (wr_en) begin
            if (led_hit)  led_d     = writedata[7:0];
            if (cnt_hit)  counter_d = writedata;
            if (cmp_hit)  compare_d = writedata;
            if (stat_hit) status_d  = status_q & ~writedata[1:0];
        end
        if (counter_q == compare_q) begin
            status_d[0] = 1'b1;
        end
        // Misalignment is flagged regardless of address decode
        if (memwrite && !aligned) begin
            status_d[1] = 1'b1;
        end
    end

    // MMIO state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= 8'd0;
            counter_q <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            status_q  <= 2'b00;
        end else begin
            led_q     <= led_d;
            counter_q <= counter_d;
            compare_q <= compare_d;
            status_q  <= status_d;
        end
    end

    // Data RAM keeps its contents across reset; reset only blocks a write
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    assign leds = led_q;
    assign irq  = status_q[0];

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed vector table, hand-written
// timing sequences and randomized traffic against a behavioural model.
module tb_dmem_mmio;

    localparam int unsigned RW = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic        irq;

    int checks = 0;
    int errors = 0;

    dmem_mmio #(.RAM_WORDS(RW)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [RW];
    bit          m_v   [RW];
    logic [7:0]  m_led;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic [1:0]  m_st;

    function automatic void model_reset();
        m_led = 8'd0;
        m_cnt = 32'd0;
        m_cmp = 32'hFFFF_FFFF;
        m_st  = 2'b00;
    endfunction

    // Returns {known, data}
    function automatic logic [32:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        off = {16'd0, a[15:2], 2'b00};
        if (a[31:16] != 16'd0) return {1'b1, 32'd0};
        if (off < 4 * RW) return {m_v[off / 4], m_ram[off / 4]};
        case (off)
            32'h8000: return {1'b1, 24'd0, m_led};
            32'h8004: return {1'b1, m_cnt};
            32'h8008: return {1'b1, m_cmp};
            32'h800C: return {1'b1, 30'd0, m_st};
            default:  return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic void model_step(input logic we, input logic [31:0] a,
                                       input logic [31:0] d);
        logic        match_now;
        logic [31:0] next_cnt;
        logic [31:0] off;
        match_now = (m_cnt == m_cmp);
        next_cnt  = m_cnt + 32'd1;
        off       = {16'd0, a[15:2], 2'b00};
        if (we && a[1:0] == 2'b00 && a[31:16] == 16'd0) begin
            if (off < 4 * RW) begin
                m_ram[off / 4] = d;
                m_v[off / 4]   = 1'b1;
            end else begin
                case (off)
                    32'h8000: m_led = d[7:0];
                    32'h8004: next_cnt = d;
                    32'h8008: m_cmp = d;
                    32'h800C: m_st = m_st & ~d[1:0];
                    default: ;
                endcase
            end
        end
        if (match_now) m_st[0] = 1'b1;
        if (we && a[1:0] != 2'b00) m_st[1] = 1'b1;
        m_cnt = next_cnt;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One cycle of traffic: drive, compare against the model, advance the model
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [32:0] r;
        @(negedge clk);
        reset = 1'b0;
        memwrite = we;
        addr = a;
        writedata = d;
        #1;
        r = model_read(a);
        if (r[32]) chk("model_readdata", readdata, r[31:0]);
        chk("model_leds", {24'd0, leds}, {24'd0, m_led});
        chk("model_irq", {31'd0, irq}, {31'd0, m_st[0]});
        model_step(we, a, d);
    endtask

    task automatic rst(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = 1'b1;
        memwrite = we;
        addr = a;
        writedata = d;
        #1;
        model_reset();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input logic we, input logic [31:0] a, input logic [31:0] d,
                                 input logic c, input logic [31:0] e, input logic [7:0] l);
        vec_t v;
        v = '{we, a, d, c, e, l, 1'b0};
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        int          kind;

        reset = 1'b1;
        memwrite = 1'b0;
        addr = 32'd0;
        writedata = 32'd0;
        for (int i = 0; i < RW; i++) m_v[i] = 1'b0;
        model_reset();

        // Directed vectors: {we, addr, wdata, check rd, expected rd, expected leds}
        addv(1, 32'h0000_0000, 32'hCAFE_F00D, 0, 32'h0,         8'h00);
        addv(1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 32'h0,         8'h00);
        addv(1, 32'h0000_00FC, 32'h1234_5678, 0, 32'h0,         8'h00);
        addv(0, 32'h0000_0004, 32'h0,         1, 32'hDEAD_BEEF, 8'h00);
        addv(0, 32'h0000_00FC, 32'h0,         1, 32'h1234_5678, 8'h00);
        addv(0, 32'h0000_0006, 32'h0,         1, 32'hDEAD_BEEF, 8'h00);
        addv(1, 32'h0000_8000, 32'h0000_00A5, 0, 32'h0,         8'h00);
        addv(0, 32'h0000_8000, 32'h0,         1, 32'h0000_00A5, 8'hA5);
        addv(1, 32'h0000_8000, 32'h0000_01FF, 0, 32'h0,         8'hA5);
        addv(0, 32'h0000_8000, 32'h0,         1, 32'h0000_00FF, 8'hFF);
        addv(1, 32'h0000_0008, 32'h1111_1111, 0, 32'h0,         8'hFF);
        addv(1, 32'h0000_0009, 32'h0000_0055, 0, 32'h0,         8'hFF);
        addv(0, 32'h0000_0008, 32'h0,         1, 32'h1111_1111, 8'hFF);
        addv(0, 32'h0000_800C, 32'h0,         1, 32'h0000_0002, 8'hFF);
        addv(1, 32'h0000_800C, 32'h0000_0002, 0, 32'h0,         8'hFF);
        addv(0, 32'h0000_800C, 32'h0,         1, 32'h0000_0000, 8'hFF);
        addv(1, 32'h0000_8001, 32'h0000_0033, 0, 32'h0,         8'hFF);
        addv(0, 32'h0000_8000, 32'h0,         1, 32'h0000_00FF, 8'hFF);
        addv(0, 32'h0000_800C, 32'h0,         1, 32'h0000_0002, 8'hFF);
        addv(1, 32'h0000_800C, 32'h0000_0002, 0, 32'h0,         8'hFF);
        addv(1, 32'h0001_0000, 32'h0000_0077, 0, 32'h0,         8'hFF);
        addv(1, 32'h0000_4000, 32'h0000_0077, 0, 32'h0,         8'hFF);
        addv(0, 32'h0001_0000, 32'h0,         1, 32'h0000_0000, 8'hFF);
        addv(0, 32'h0000_4000, 32'h0,         1, 32'h0000_0000, 8'hFF);
        addv(0, 32'h0000_0000, 32'h0,         1, 32'hCAFE_F00D, 8'hFF);
        addv(0, 32'h0000_8000, 32'h0,         1, 32'h0000_00FF, 8'hFF);
        addv(1, 32'h0000_8010, 32'h0000_0099, 0, 32'h0,         8'hFF);
        addv(0, 32'h0000_8010, 32'h0,         1, 32'h0000_0000, 8'hFF);

        rst(0, 32'd0, 32'd0);
        rst(0, 32'd0, 32'd0);

        // Reset values
        step(0, 32'h0000_800C, 32'd0);
        chk("rst_status", readdata, 32'd0);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        step(0, 32'h0000_8008, 32'd0);
        chk("rst_compare", readdata, 32'hFFFF_FFFF);

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), {24'd0, leds}, {24'd0, vecs[i].exp_leds});
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // COMPARE=10 right after reset; MATCH follows COUNTER==10
        rst(0, 32'd0, 32'd0);
        step(0, 32'h0000_8004, 32'd0);
        chk("cnt_first", readdata, 32'd0);
        step(1, 32'h0000_8008, 32'd10);
        for (int k = 2; k <= 10; k++) begin
            step(0, 32'h0000_8004, 32'd0);
            chk("cnt_seq", readdata, 32'(k));
            chk("irq_before_match", {31'd0, irq}, 32'd0);
        end
        step(0, 32'h0000_8004, 32'd0);
        chk("cnt_11", readdata, 32'd11);
        chk("irq_after_match", {31'd0, irq}, 32'd1);
        step(1, 32'h0000_800C, 32'd1);
        chk("irq_held", {31'd0, irq}, 32'd1);
        step(0, 32'h0000_800C, 32'd0);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        chk("status_cleared", readdata, 32'd0);
        // Clear collides with a fresh match: set wins
        step(1, 32'h0000_8008, m_cnt + 32'd2);
        step(0, 32'h0000_800C, 32'd0);
        chk("irq_pre_collide", {31'd0, irq}, 32'd0);
        step(1, 32'h0000_800C, 32'd1);
        step(0, 32'h0000_800C, 32'd0);
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        chk("status_set_wins", readdata, 32'd1);

        // COUNTER wrap with COMPARE at its reset value
        rst(0, 32'd0, 32'd0);
        step(1, 32'h0000_8004, 32'hFFFF_FFFE);
        step(0, 32'h0000_8004, 32'd0);
        chk("wrap_fe", readdata, 32'hFFFF_FFFE);
        step(0, 32'h0000_8004, 32'd0);
        chk("wrap_ff", readdata, 32'hFFFF_FFFF);
        chk("wrap_irq_pre", {31'd0, irq}, 32'd0);
        step(0, 32'h0000_8004, 32'd0);
        chk("wrap_00", readdata, 32'd0);
        chk("wrap_irq", {31'd0, irq}, 32'd1);

        // Reset mid-run with a colliding LED write; RAM survives
        step(1, 32'h0000_0010, 32'h0BAD_CAFE);
        step(1, 32'h0000_8000, 32'h0000_003C);
        step(0, 32'h0000_8000, 32'd0);
        chk("pre_rst_leds", {24'd0, leds}, 32'h3C);
        rst(1, 32'h0000_8000, 32'h0000_005A);
        step(0, 32'h0000_8004, 32'd0);
        chk("rst_mid_cnt0", readdata, 32'd0);
        chk("rst_mid_leds", {24'd0, leds}, 32'd0);
        step(0, 32'h0000_8004, 32'd0);
        chk("rst_mid_cnt1", readdata, 32'd1);
        step(0, 32'h0000_0010, 32'd0);
        chk("rst_mid_ram", readdata, 32'h0BAD_CAFE);
        step(0, 32'h0000_8000, 32'd0);
        chk("rst_mid_led_reg", readdata, 32'd0);

        // Fill RAM so every word is known, then random traffic
        for (int i = 0; i < RW; i++) step(1, 32'(i * 4), $urandom);
        for (int n = 0; n < 3000; n++) begin
            kind = $urandom_range(0, 7);
            we   = 1'($urandom_range(0, 1));
            d    = $urandom;
            a    = {16'd0, 14'($urandom_range(0, RW - 1)), 2'b00};
            case (kind)
                0, 1, 2: ;
                3: a = 32'h0000_8000;
                4: a = 32'h0000_8004;
                5: begin
                    a = 32'h0000_8008;
                    d = m_cnt + 32'($urandom_range(0, 6));
                end
                6: begin
                    a = 32'h0000_800C;
                    d = 32'($urandom_range(0, 3));
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h0000_8010;
                        1: a = 32'h0000_4000;
                        2: a = a | 32'h0001_0000;
                        default: a = 32'h8000_8004;
                    endcase
                end
            endcase
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 199) == 0) rst(we, a, d);
            else step(we, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
